// File: rtl/csr_trap_unit.sv
// -----------------------------------------------------------------------------
// csr_trap_unit
//
// Machine-mode CSR file and trap controller. Sits beside the MW stage of the
// pipeline. It holds mstatus/mie/mip/mtvec/mepc/mcause, synchronises the
// asynchronous external and timer interrupt requests, decides trap entry and
// drives the PC redirect for trap entry and mret. The hazard/forwarding logic
// flushes on `interrupt` and `is_mret`.
//
// Parameters
//   SYNC_STAGES  flip-flop depth of each irq synchroniser (values below 2 are
//                raised to 2)
//   RESET_MTVEC  reset value of mtvec
//
// Optional feature (compile-time macro CSR_VECTORED_MODE_EN)
//   defined   : mtvec[1:0] is a writable MODE field; MODE==01 vectors trap
//               entry to base + 4*cause, any other MODE enters at base.
//   undefined : mtvec[1:0] reads 0, MODE writes are dropped, entry is always
//               at base.
//
// Ports
//   clk          clock
//   rst          asynchronous active-high reset
//   csr_addr     CSR address of the MW instruction
//   csr_op       00 none, 01 write, 10 set, 11 clear
//   csr_wdata    rs1/imm operand
//   csr_rdata    combinational read of csr_addr (0 for unimplemented CSRs)
//   pc_mw        PC of the MW-stage instruction
//   mret_mw      MW instruction is mret
//   ext_irq      external interrupt request (asynchronous level)
//   timer_irq    timer interrupt request (asynchronous level)
//   interrupt    00 run, 01 trap entry this cycle, 10 in handler
//   is_mret      mret redirect this cycle
//   redirect_pc  redirect target, valid when interrupt==01 or is_mret
// -----------------------------------------------------------------------------
module csr_trap_unit #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic [31:0] pc_mw,
    input  logic        mret_mw,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [1:0]  interrupt,
    output logic        is_mret,
    output logic [31:0] redirect_pc
);

    // A single flop cannot resolve metastability, so depth is at least 2.
    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [3:0] CAUSE_EXT   = 4'd11;
    localparam logic [3:0] CAUSE_TIMER = 4'd7;

`ifdef CSR_VECTORED_MODE_EN
    localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFC;
`endif

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_ENTER   = 2'b01,
        ST_HANDLER = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [SYNC_N-1:0]  ext_sync_q;
    logic [SYNC_N-1:0]  timer_sync_q;
    logic               mst_mie_q, mst_mie_d;
    logic               mst_mpie_q, mst_mpie_d;
    logic               mie_meie_q, mie_meie_d;
    logic               mie_mtie_q, mie_mtie_d;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;

    logic               ext_s;
    logic               timer_s;
    logic [31:0]        mstatus_val;
    logic [31:0]        mie_val;
    logic [31:0]        mip_val;
    logic               pend;
    logic [3:0]         trap_cause;
    logic [31:0]        trap_target;
    logic [31:0]        csr_wval;
    logic               csr_we;
    logic               take_trap;
    logic               do_mret;

    // -------------------------------------------------------------------------
    // Interrupt request synchronisers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_sync_q   <= '0;
            timer_sync_q <= '0;
        end else begin
            ext_sync_q   <= {ext_sync_q[SYNC_N-2:0], ext_irq};
            timer_sync_q <= {timer_sync_q[SYNC_N-2:0], timer_irq};
        end
    end

    assign ext_s   = ext_sync_q[SYNC_N-1];
    assign timer_s = timer_sync_q[SYNC_N-1];

    // -------------------------------------------------------------------------
    // Architectural views of the sparse CSRs
    // -------------------------------------------------------------------------
    assign mstatus_val = {24'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
    assign mie_val     = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 7'b0};
    assign mip_val     = {20'b0, ext_s, 3'b0, timer_s, 7'b0};

    assign pend = mst_mie_q & ((ext_s & mie_meie_q) | (timer_s & mie_mtie_q));

    // External outranks timer when both are pending and enabled.
    assign trap_cause = (ext_s & mie_meie_q) ? CAUSE_EXT : CAUSE_TIMER;

    // Entry target is computed in ENTER, after mcause has been captured, so the
    // vector offset comes from the latched cause rather than the live irqs.
    always_comb begin
        trap_target = {mtvec_q[31:2], 2'b00};
`ifdef CSR_VECTORED_MODE_EN
        if (mtvec_q[1:0] == 2'b01) begin
            trap_target = {mtvec_q[31:2], 2'b00} + {26'b0, mcause_q[3:0], 2'b00};
        end
`endif
    end

    // -------------------------------------------------------------------------
    // CSR read port
    // -------------------------------------------------------------------------
    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            ADDR_MSTATUS: csr_rdata = mstatus_val;
            ADDR_MIE:     csr_rdata = mie_val;
            ADDR_MTVEC:   csr_rdata = mtvec_q;
            ADDR_MEPC:    csr_rdata = mepc_q;
            ADDR_MCAUSE:  csr_rdata = mcause_q;
            ADDR_MIP:     csr_rdata = mip_val;
            default:      csr_rdata = 32'h0;
        endcase
    end

    // Read-modify-write value, built from the architectural read so that set
    // and clear see exactly what software would read.
    always_comb begin
        csr_wval = csr_rdata;
        case (csr_op)
            2'b01:   csr_wval = csr_wdata;
            2'b10:   csr_wval = csr_rdata | csr_wdata;
            2'b11:   csr_wval = csr_rdata & ~csr_wdata;
            default: csr_wval = csr_rdata;
        endcase
    end

    // -------------------------------------------------------------------------
    // Trap FSM and CSR next-state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mst_mie_d   = mst_mie_q;
        mst_mpie_d  = mst_mpie_q;
        mie_meie_d  = mie_meie_q;
        mie_mtie_d  = mie_mtie_q;
        mtvec_d     = mtvec_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        interrupt   = 2'b00;
        is_mret     = 1'b0;
        redirect_pc = 32'h0;
        csr_we      = 1'b0;
        take_trap   = 1'b0;
        do_mret     = 1'b0;

        case (state_q)
            ST_RUN: begin
                csr_we = 1'b1;
                // mret wins over a pending interrupt; the interrupt is
                // re-evaluated next cycle against the restored MIE.
                if (mret_mw) begin
                    do_mret = 1'b1;
                end else if (pend) begin
                    // The interrupted instruction does not retire, so its
                    // CSR write must not land.
                    take_trap = 1'b1;
                    csr_we    = 1'b0;
                    state_d   = ST_ENTER;
                end
            end
            ST_ENTER: begin
                // The MW instruction here is being flushed by the redirect,
                // so neither its CSR write nor an mret is honoured.
                interrupt   = 2'b01;
                redirect_pc = trap_target;
                state_d     = ST_HANDLER;
            end
            ST_HANDLER: begin
                interrupt = 2'b10;
                csr_we    = 1'b1;
                if (mret_mw) begin
                    do_mret = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (do_mret) begin
            is_mret     = 1'b1;
            redirect_pc = mepc_q;
        end

        if (csr_we && (csr_op != 2'b00)) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mst_mie_d  = csr_wval[3];
                    mst_mpie_d = csr_wval[7];
                end
                ADDR_MIE: begin
                    mie_meie_d = csr_wval[11];
                    mie_mtie_d = csr_wval[7];
                end
                ADDR_MTVEC:  mtvec_d  = csr_wval & MTVEC_WMASK;
                ADDR_MEPC:   mepc_d   = csr_wval & 32'hFFFF_FFFC;
                ADDR_MCAUSE: mcause_d = csr_wval;
                default: begin
                end
            endcase
        end

        // mret's mstatus update takes precedence over a same-cycle CSR write.
        if (do_mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end

        if (take_trap) begin
            mepc_d     = pc_mw & 32'hFFFF_FFFC;
            mcause_d   = {1'b1, 27'b0, trap_cause};
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_meie_q <= 1'b0;
            mie_mtie_q <= 1'b0;
            mtvec_q    <= RESET_MTVEC & MTVEC_WMASK;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_meie_q <= mie_meie_d;
            mie_mtie_q <= mie_mtie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
module tb_csr_trap_unit;

    localparam int unsigned SYNC     = 3;
    localparam logic [31:0] RST_TVEC = 32'h0000_0200;

`ifdef CSR_VECTORED_MODE_EN
    localparam logic [31:0] TVEC_MASK    = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_MTVEC101 = 32'h0000_0101;
    localparam logic [31:0] EXP_VEC_PC   = 32'h0000_011C;
`else
    localparam logic [31:0] TVEC_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] EXP_MTVEC101 = 32'h0000_0100;
    localparam logic [31:0] EXP_VEC_PC   = 32'h0000_0100;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] csr_addr = 12'h0;
    logic [1:0]  csr_op = 2'b00;
    logic [31:0] csr_wdata = 32'h0;
    logic [31:0] csr_rdata;
    logic [31:0] pc_mw = 32'h0;
    logic        mret_mw = 1'b0;
    logic        ext_irq = 1'b0;
    logic        timer_irq = 1'b0;
    logic [1:0]  interrupt;
    logic        is_mret;
    logic [31:0] redirect_pc;

    int vectors = 0;
    int miscompares = 0;

    // Reference CSR contents for the randomized access phase (irqs held low).
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
    logic [11:0] addrs [7];

    csr_trap_unit #(
        .SYNC_STAGES(SYNC),
        .RESET_MTVEC(RST_TVEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_addr   (csr_addr),
        .csr_op     (csr_op),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .pc_mw      (pc_mw),
        .mret_mw    (mret_mw),
        .ext_irq    (ext_irq),
        .timer_irq  (timer_irq),
        .interrupt  (interrupt),
        .is_mret    (is_mret),
        .redirect_pc(redirect_pc)
    );

    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    function automatic logic [31:0] mread(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;   // mip is 0 while irqs are low
        endcase
    endfunction

    task automatic mwrite(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w);
        logic [31:0] oldv, newv;
        oldv = mread(a);
        newv = (op == 2'b01) ? w : (op == 2'b10) ? (oldv | w) : (oldv & ~w);
        case (a)
            12'h300: m_mstatus = newv & 32'h0000_0088;
            12'h304: m_mie     = newv & 32'h0000_0880;
            12'h305: m_mtvec   = newv & TVEC_MASK;
            12'h341: m_mepc    = newv & 32'hFFFF_FFFC;
            12'h342: m_mcause  = newv;
            default: ;
        endcase
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w);
        csr_addr = a; csr_op = op; csr_wdata = w;
        cycle();
        csr_op = 2'b00;
    endtask

    initial begin
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};

        // ---------------- reset state ----------------
        cycle(); cycle();
        rst = 1'b0;
        #1;
        chk("rst_interrupt", {30'b0, interrupt}, 32'h0);
        chk("rst_is_mret", {31'b0, is_mret}, 32'h0);
        chk("rst_redirect", redirect_pc, 32'h0);
        rd(12'h300, 32'h0, "rst_mstatus");
        rd(12'h304, 32'h0, "rst_mie");
        rd(12'h305, RST_TVEC, "rst_mtvec");
        rd(12'h341, 32'h0, "rst_mepc");
        rd(12'h342, 32'h0, "rst_mcause");
        rd(12'h344, 32'h0, "rst_mip");
        cycle();
        rd(12'h7C0, 32'h0, "rst_unimpl");

        // ---------------- randomized CSR accesses ----------------
        m_mstatus = 32'h0; m_mie = 32'h0; m_mtvec = RST_TVEC;
        m_mepc = 32'h0; m_mcause = 32'h0;
        for (int n = 0; n < 48; n++) begin
            logic [11:0] a;
            logic [1:0]  op;
            logic [31:0] w;
            a  = addrs[$urandom_range(0, 6)];
            op = 2'($urandom_range(0, 3));
            w  = $urandom;
            csr_addr = a; csr_op = op; csr_wdata = w;
            #1;
            chk("rand_read", csr_rdata, mread(a));
            cycle();
            csr_op = 2'b00;
            if (op != 2'b00) mwrite(a, op, w);
        end
        chk("rand_no_irq", {30'b0, interrupt}, 32'h0);
        for (int i = 0; i < 7; i++) begin
            csr_addr = addrs[i];
            #1;
            chk("rand_final", csr_rdata, mread(addrs[i]));
        end

        // ---------------- fresh start for the trap flow ----------------
        rst = 1'b1; cycle(); rst = 1'b0;
        wr(12'h305, 2'b01, 32'h0000_0100);
        wr(12'h304, 2'b10, 32'h0000_0800);
        wr(12'h300, 2'b10, 32'h0000_0008);

        // External irq: SYNC edges stay in RUN, entry shows after SYNC+1.
        ext_irq = 1'b1; pc_mw = 32'h0000_0040;
        for (int i = 1; i <= SYNC; i++) begin
            cycle();
            chk("sync_wait_run", {30'b0, interrupt}, 32'h0);
        end
        // Coincident CSR write with trap take must be dropped.
        csr_addr = 12'h305; csr_op = 2'b01; csr_wdata = 32'h0000_0300;
        #1;
        chk("take_is_mret", {31'b0, is_mret}, 32'h0);
        cycle();
        csr_op = 2'b00; pc_mw = 32'h0000_0044;
        #1;
        chk("enter_interrupt", {30'b0, interrupt}, 32'h1);
        chk("enter_redirect", redirect_pc, 32'h0000_0100);
        ext_irq = 1'b0;
        cycle();
        chk("handler_interrupt", {30'b0, interrupt}, 32'h2);
        rd(12'h341, 32'h0000_0040, "handler_mepc");
        rd(12'h342, 32'h8000_000B, "handler_mcause");
        rd(12'h300, 32'h0000_0080, "handler_mstatus");
        rd(12'h305, 32'h0000_0100, "suppressed_mtvec");
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("handler_hold", {30'b0, interrupt}, 32'h2);
        end
        rd(12'h344, 32'h0, "mip_after_deassert");

        // mret from the handler.
        mret_mw = 1'b1;
        #1;
        chk("mret_is_mret", {31'b0, is_mret}, 32'h1);
        chk("mret_redirect", redirect_pc, 32'h0000_0040);
        cycle();
        mret_mw = 1'b0;
        #1;
        chk("post_mret_interrupt", {30'b0, interrupt}, 32'h0);
        rd(12'h300, 32'h0000_0088, "post_mret_mstatus");

        // ---------------- simultaneous ext + timer ----------------
        wr(12'h304, 2'b10, 32'h0000_0080);
        rd(12'h304, 32'h0000_0880, "mie_both");
        ext_irq = 1'b1; timer_irq = 1'b1; pc_mw = 32'h0000_0080;
        for (int i = 1; i <= SYNC; i++) cycle();
        rd(12'h344, 32'h0000_0880, "mip_both");
        cycle();
        chk("both_enter", {30'b0, interrupt}, 32'h1);
        ext_irq = 1'b0;
        cycle();
        rd(12'h342, 32'h8000_000B, "both_mcause_ext");
        rd(12'h341, 32'h0000_0080, "both_mepc");
        for (int i = 0; i < 4; i++) cycle();
        rd(12'h344, 32'h0000_0080, "mip_timer_only");

        // mret in handler, then mret again in RUN while timer is pending.
        mret_mw = 1'b1;
        #1;
        chk("mret2_redirect", redirect_pc, 32'h0000_0080);
        cycle();
        #1;
        chk("run_mret_is_mret", {31'b0, is_mret}, 32'h1);
        chk("run_mret_interrupt", {30'b0, interrupt}, 32'h0);
        chk("run_mret_redirect", redirect_pc, 32'h0000_0080);
        cycle();
        mret_mw = 1'b0; pc_mw = 32'h0000_00C4;
        #1;
        chk("reeval_interrupt", {30'b0, interrupt}, 32'h0);
        chk("reeval_is_mret", {31'b0, is_mret}, 32'h0);
        cycle();
        chk("timer_enter", {30'b0, interrupt}, 32'h1);
        chk("timer_enter_pc", redirect_pc, 32'h0000_0100);
        cycle();
        rd(12'h342, 32'h8000_0007, "timer_mcause");
        rd(12'h341, 32'h0000_00C4, "timer_mepc");
        rd(12'h300, 32'h0000_0080, "timer_mstatus");

        // ---------------- mtvec MODE ----------------
        wr(12'h305, 2'b01, 32'h0000_0101);
        rd(12'h305, EXP_MTVEC101, "mtvec_mode_read");
        mret_mw = 1'b1;
        #1;
        chk("mret3_redirect", redirect_pc, 32'h0000_00C4);
        cycle();
        mret_mw = 1'b0;
        cycle();
        chk("vec_enter", {30'b0, interrupt}, 32'h1);
        chk("vec_redirect", redirect_pc, EXP_VEC_PC);
        cycle();
        chk("vec_handler", {30'b0, interrupt}, 32'h2);

        // ---------------- reset mid-handler ----------------
        rst = 1'b1;
        #1;
        chk("midrst_interrupt", {30'b0, interrupt}, 32'h0);
        chk("midrst_is_mret", {31'b0, is_mret}, 32'h0);
        chk("midrst_redirect", redirect_pc, 32'h0);
        rd(12'h300, 32'h0, "midrst_mstatus");
        rd(12'h305, RST_TVEC, "midrst_mtvec");
        timer_irq = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        chk("after_rst_interrupt", {30'b0, interrupt}, 32'h0);
        rd(12'h344, 32'h0, "after_rst_mip");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR and trap controller for the pipelined core; the producer of the `interrupt` and `is_mret` redirect signals that the hazard/forwarding logic consumes to flush.
- Holds mstatus, mie, mip, mtvec, mepc and mcause.
- Synchronises external and timer interrupt requests, decides trap entry, and drives the PC redirect target for trap entry and mret.
- Sits beside the MW stage. CSR read/write and mret are presented by the MW-stage instruction.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the irq synchronisers (minimum 2)
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- csr_addr  in  12  CSR address of the MW instruction
- csr_op  in  2  00 none, 01 write, 10 set, 11 clear
- csr_wdata  in  32  rs1/imm operand
- csr_rdata  out  32  combinational read of csr_addr; 0 for unimplemented addresses
- pc_mw  in  32  PC of the MW-stage instruction
- mret_mw  in  1  MW instruction is mret
- ext_irq  in  1  asynchronous external interrupt request, level
- timer_irq  in  1  asynchronous timer interrupt request, level
- interrupt  out  2  00 run, 01 trap entry this cycle, 10 in handler
- is_mret  out  1  mret redirect this cycle
- redirect_pc  out  32  target PC; valid when interrupt==01 or is_mret

Behaviour:
- CSR map:
  - mstatus 0x300: only MIE[3] and MPIE[7] writable; all other bits read 0.
  - mie 0x304: only bits [11] and [7] writable.
  - mtvec 0x305.
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342.
  - mip 0x344: read-only, reflects the synchronised ext and timer requests.
- Writes with csr_op 01/10/11 take effect at the clock edge: write = wdata, set = old|wdata, clear = old&~wdata. Writes to unimplemented or read-only addresses are ignored.
- Reset: all CSRs 0 except mtvec=RESET_MTVEC; synchronisers cleared; interrupt=00, is_mret=0, redirect_pc=0; FSM in RUN.
- Pending condition: pend = mstatus.MIE & |(mip & mie).
- Priority: external (cause 11) over timer (cause 7).
- FSM RUN:
  - If pend and not mret_mw, go to ENTER. Register mepc<=pc_mw, mcause<={1'b1,27'b0,cause}, MPIE<=MIE, MIE<=0.
  - The MW instruction's CSR write in that same cycle is suppressed, because the interrupted instruction is not retired.
- FSM ENTER (exactly one cycle):
  - interrupt=01, redirect_pc=mtvec base ({mtvec[31:2],2'b00}).
  - Go to HANDLER.
- FSM HANDLER:
  - interrupt=10. CSR accesses operate normally.
  - On mret_mw: is_mret=1 combinationally in that cycle, redirect_pc=mepc, MIE<=MPIE, MPIE<=1. Go to RUN.
- mret_mw in RUN (no trap active): same mret action; stays in RUN.
- mret_mw and pend in the same RUN cycle: mret wins. The interrupt is re-evaluated the next cycle with the restored MIE.
- irq deasserted while in ENTER/HANDLER: no effect on FSM; mip simply follows the synchronised level.
- Latency: raw irq edge to interrupt==01 is SYNC_STAGES+1 cycles, given MIE and mie are set.
- rst asserted mid-handler: immediate return to RUN with reset values; no redirect issued.

Optional Feature:
- Macro: CSR_VECTORED_MODE_EN
- Defined: mtvec[1:0] is writable as MODE. With MODE==01, redirect_pc on entry = base + 4*cause (ext → base+0x2C, timer → base+0x1C). MODE==00 behaves as direct.
- Undefined: mtvec[1:0] reads 0, MODE writes are ignored, and entry is always to base.

Test Plan:
- Reset → all CSR reads 0, mtvec==RESET_MTVEC, interrupt==00, is_mret==0.
- Write mtvec=0x100, set mie=0x800 and mstatus=0x8, pulse ext_irq with pc_mw=0x40 → after SYNC_STAGES+1 cycles:
  - interrupt==01 for one cycle, redirect_pc==0x100;
  - then mepc==0x40, mcause==0x8000000B, mstatus==0x80, interrupt==10.
- In HANDLER, mret_mw=1 → same cycle is_mret==1, redirect_pc==0x40; next cycle mstatus==0x88, interrupt==00.
- ext_irq and timer_irq together, both enabled → mcause==0x8000000B; after mret with timer still high → second entry with mcause==0x80000007.
- mret_mw with pend in the same RUN cycle → is_mret==1 only, no entry that cycle; entry on the following cycle. CSR write coincident with entry → target CSR unchanged.
- CSR_VECTORED_MODE_EN defined, mtvec=0x101, timer trap → redirect_pc==0x11C. Undefined: same stimulus → mtvec reads 0x100, redirect_pc==0x100.
